// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, halt opcode default and fetch state encoding.
// Opcode-based halting is built only when INSTR_FETCH_HALT_OP_EN is defined.
package instr_fetch_pkg;

  localparam int IF_ADDR_W = 8;
  localparam int IF_INSTR_W = 16;
  localparam logic [3:0] IF_HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  function automatic logic op_is(
    input logic [3:0] op,
    input logic [3:0] match
  );
    return op == match;
  endfunction

endpackage

// File: rtl/instr_fetch_skid.sv
// fetch_skid_buf: one-entry instruction+pc holding slot.
// Flush beats load, load beats drain (load while draining replaces the entry).
module fetch_skid_buf #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] data,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: ROM-fed fetch stage with skid, redirect and halt handling.
// Define INSTR_FETCH_HALT_OP_EN to stop fetch on a HALT_OPCODE word.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int               ADDR_W      = IF_ADDR_W,
  parameter int               INSTR_W     = IF_INSTR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [3:0]       HALT_OPCODE = IF_HALT_OPCODE
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load_done,
  input  logic [ADDR_W-1:0]  i_max_addr,
  output logic               o_rom_en,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid,
  output logic               o_halt
);

`ifdef INSTR_FETCH_HALT_OP_EN
  localparam bit HALT_OP_EN = 1'b1;
`else
  localparam bit HALT_OP_EN = 1'b0;
`endif

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0]  pc_req_q;
  logic [ADDR_W-1:0]  fly_pc_q;
  logic               fly_q;
  logic               halt_pend_q;

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [ADDR_W-1:0]  skid_pc;
  logic               skid_load;
  logic               skid_drain;
  logic               skid_flush;

  logic               active;
  logic               redir;
  logic               redir_oor;
  logic               xfer;
  logic               out_free;
  logic               arrive;
  logic               arrive_halt;
  logic               halt_done;
  logic               issue;
  logic               last_req;
  logic               drained;
  logic               room;
  logic [1:0]         occ_next;

  assign active    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign redir     = i_redirect && active;
  assign redir_oor = redir && (i_redirect_addr > i_max_addr);
  assign xfer      = o_valid && !i_stall;
  assign out_free  = !o_valid || xfer;

  // Words returning after a halt opcode are dropped on arrival.
  assign arrive      = fly_q && !halt_pend_q;
  assign arrive_halt = HALT_OP_EN && arrive
                    && op_is(i_rom_data[INSTR_W-1 -: 4], HALT_OPCODE);
  assign halt_done   = HALT_OP_EN && xfer && halt_pend_q
                    && op_is(o_instr[INSTR_W-1 -: 4], HALT_OPCODE);

  // Output+skid hold two words; only issue when the word returning
  // next cycle still has a slot even if the consumer stalls then.
  assign occ_next = {1'b0, o_valid} + {1'b0, skid_valid}
                  + {1'b0, arrive} - {1'b0, xfer};
  assign room     = occ_next <= 2'd1;

  assign issue = (state_q == ST_FETCH) && !redir
              && !halt_pend_q && !arrive_halt
              && !(i_stall && (fly_q || skid_valid))
              && room;

  assign last_req = pc_req_q == i_max_addr;
  assign drained  = !fly_q && !skid_valid && !o_valid;

  assign skid_flush = redir || halt_done;
  assign skid_load  = arrive && (!out_free || skid_valid);
  assign skid_drain = out_free && skid_valid;

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .flush     (skid_flush),
    .load_data (i_rom_data),
    .load_pc   (fly_pc_q),
    .valid     (skid_valid),
    .data      (skid_data),
    .pc        (skid_pc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_load_done) state_d = ST_FETCH;
      end
      ST_FETCH, ST_DRAIN: begin
        if (redir) begin
          state_d = redir_oor ? ST_HALT : ST_FETCH;
        end else if (halt_done) begin
          state_d = ST_HALT;
        end else if (state_q == ST_FETCH) begin
          if (issue && last_req) state_d = ST_DRAIN;
        end else if (drained) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rom_en   = issue;
    o_rom_addr = issue ? pc_req_q : '0;
    o_halt     = state_q == ST_HALT;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_req_q    <= START_ADDR;
      fly_q       <= 1'b0;
      fly_pc_q    <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      fly_q <= issue;
      if (issue) begin
        fly_pc_q <= pc_req_q;
        pc_req_q <= pc_req_q + ADDR_W'(1);
      end
      if (redir) begin
        pc_req_q <= i_redirect_addr;
      end
      if (redir) begin
        halt_pend_q <= 1'b0;
      end else if (arrive_halt) begin
        halt_pend_q <= 1'b1;
      end
    end
  end

  // Skid always drains ahead of fresh ROM data to keep program order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_instr <= '0;
      o_pc    <= '0;
    end else if (redir || halt_done) begin
      o_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        o_valid <= 1'b1;
        o_instr <= skid_data;
        o_pc    <= skid_pc;
      end else if (arrive) begin
        o_valid <= 1'b1;
        o_instr <= i_rom_data;
        o_pc    <= fly_pc_q;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
